// File: rtl/neck_power_sequencer.sv
// Welder IGBT power sequencer: cuts power on a neck event, restores it on arc
// detection or timeout, then blanks further requests for a fixed window.
module neck_power_sequencer #(
   parameter int                 OFF_MIN = 200,
   parameter int                 OFF_MAX = 20000,
   parameter int                 BLANK   = 5000,
   parameter logic signed [12:0] ARC_TH  = 13'sd1500,
   parameter int                 CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ctrl_switch,
   input  logic               neck_req,
   input  logic               adc_valid,
   input  logic signed [12:0] adc_data,
   output logic               power_switch,
   output logic [1:0]         state,
   output logic [15:0]        cut_count,
   output logic               timeout_flag
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CUT    = 2'd1,
      ST_BLANK  = 2'd2,
      ST_BYPASS = 2'd3
   } seq_state_t;

   localparam logic [CNT_W-1:0] OFF_MIN_M1 = CNT_W'(OFF_MIN - 1);
   localparam logic [CNT_W-1:0] OFF_MAX_M1 = CNT_W'(OFF_MAX - 1);
   localparam logic [CNT_W-1:0] BLANK_M1   = CNT_W'(BLANK - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   seq_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             arc_latch_r;
   logic             power_r;
   logic [15:0]      cut_count_r;
   logic             timeout_r;

   logic             arc_now_s;
   logic             min_done_s;
   logic             at_max_s;
   logic             blank_done_s;

   // Bridge rupture is a signed threshold compare on a qualified sample.
   assign arc_now_s    = adc_valid && (adc_data >= ARC_TH);
   assign min_done_s   = (cnt_r >= OFF_MIN_M1);
   assign at_max_s     = (cnt_r == OFF_MAX_M1);
   assign blank_done_s = (cnt_r == BLANK_M1);

   // Sequencer FSM with registered gate command, counter and status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BLANK;
         cnt_r       <= CNT_ZERO;
         arc_latch_r <= 1'b0;
         power_r     <= 1'b0;
         cut_count_r <= 16'd0;
         timeout_r   <= 1'b0;
      end else if (!ctrl_switch) begin
         // Bypass overrides everything, including an in-progress cut.
         state_r <= ST_BYPASS;
         cnt_r   <= CNT_ZERO;
         power_r <= 1'b1;
      end else begin
         case (state_r)
            ST_BYPASS: begin
               state_r <= ST_BLANK;
               cnt_r   <= CNT_ZERO;
               power_r <= 1'b1;
            end
            ST_IDLE: begin
               if (neck_req) begin
                  state_r     <= ST_CUT;
                  cnt_r       <= CNT_ZERO;
                  arc_latch_r <= 1'b0;
                  power_r     <= 1'b0;
                  if (cut_count_r != 16'hFFFF) begin
                     cut_count_r <= cut_count_r + 16'd1;
                  end
               end else begin
                  power_r <= 1'b1;
               end
            end
            ST_CUT: begin
               // An arc exit wins over a simultaneous timeout.
               if (min_done_s && (arc_latch_r || arc_now_s)) begin
                  state_r <= ST_BLANK;
                  cnt_r   <= CNT_ZERO;
                  power_r <= 1'b1;
               end else if (at_max_s) begin
                  state_r   <= ST_BLANK;
                  cnt_r     <= CNT_ZERO;
                  power_r   <= 1'b1;
                  timeout_r <= 1'b1;
               end else begin
                  cnt_r       <= cnt_r + CNT_ONE;
                  arc_latch_r <= arc_latch_r | arc_now_s;
                  power_r     <= 1'b0;
               end
            end
            ST_BLANK: begin
               power_r <= 1'b1;
               if (blank_done_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_BLANK;
               cnt_r   <= CNT_ZERO;
               power_r <= 1'b1;
            end
         endcase
      end
   end

   assign power_switch = power_r;
   assign state        = state_r;
   assign cut_count    = cut_count_r;
   assign timeout_flag = timeout_r;

endmodule

// File: tb/tb_neck_power_sequencer.sv
// Directed self-checking bench for neck_power_sequencer with short timing
// parameters; all inputs change and outputs are sampled on the falling edge.
module tb_neck_power_sequencer;

   logic               clk;
   logic               rst_n;
   logic               ctrl_switch;
   logic               neck_req;
   logic               adc_valid;
   logic signed [12:0] adc_data;
   logic               power_switch;
   logic [1:0]         state;
   logic [15:0]        cut_count;
   logic               timeout_flag;

   int n_checks = 0;
   int n_errors = 0;
   int exp_count = 0;
   int width;

   neck_power_sequencer #(
      .OFF_MIN (4),
      .OFF_MAX (10),
      .BLANK   (6),
      .ARC_TH  (13'sd1000),
      .CNT_W   (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctrl_switch  (ctrl_switch),
      .neck_req     (neck_req),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .power_switch (power_switch),
      .state        (state),
      .cut_count    (cut_count),
      .timeout_flag (timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse neck_req from IDLE and count low cycles of power_switch.
   // arc_c < 0 drives arc_val valid every cycle, else only at cycle arc_c.
   task automatic run_cut(input int arc_c, input logic signed [12:0] arc_val, output int w);
      int c;
      neck_req = 1'b1;
      @(negedge clk);
      neck_req = 1'b0;
      check_val("cut_entry_state", 32'(state), 32'd1);
      c = 0;
      w = 0;
      while (power_switch == 1'b0 && c < 40) begin
         adc_valid = (arc_c < 0) || (c == arc_c);
         adc_data  = arc_val;
         w++;
         c++;
         @(negedge clk);
      end
      adc_valid = 1'b0;
      adc_data  = 13'sd0;
   endtask

   task automatic check_blank();
      for (int i = 0; i < 6; i++) begin
         check_val("blank_state", 32'(state), 32'd2);
         @(negedge clk);
      end
      check_val("idle_state", 32'(state), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      ctrl_switch = 1'b1;
      neck_req    = 1'b0;
      adc_valid   = 1'b0;
      adc_data    = 13'sd0;

      // 1: reset values and idle entry
      repeat (2) @(negedge clk);
      check_val("rst_power", 32'(power_switch), 32'd0);
      check_val("rst_state", 32'(state), 32'd2);
      check_val("rst_count", 32'(cut_count), 32'd0);
      check_val("rst_timeout", 32'(timeout_flag), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("first_edge_power", 32'(power_switch), 32'd1);
      for (int i = 1; i < 6; i++) begin
         check_val("init_blank", 32'(state), 32'd2);
         @(negedge clk);
      end
      check_val("init_idle", 32'(state), 32'd0);
      check_val("init_count", 32'(cut_count), 32'd0);

      // 2: early arc held to OFF_MIN
      run_cut(1, 13'sd1200, width);
      exp_count++;
      check_val("early_arc_width", 32'(width), 32'd4);
      check_val("early_arc_count", 32'(cut_count), 32'(exp_count));
      check_val("early_arc_timeout", 32'(timeout_flag), 32'd0);
      check_blank();

      // 4a: neck_req held high with arc every cycle: 4 low, 6 blank + 1 idle high
      neck_req  = 1'b1;
      adc_valid = 1'b1;
      adc_data  = 13'sd1200;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         check_val("retrigger_power", 32'(power_switch), ((i % 11) < 4) ? 32'd0 : 32'd1);
      end
      exp_count += 2;
      check_val("retrigger_count", 32'(cut_count), 32'(exp_count));

      // 4b: bypass mid-CUT
      @(negedge clk);
      exp_count++;
      check_val("bypass_pre_state", 32'(state), 32'd1);
      @(negedge clk);
      ctrl_switch = 1'b0;
      neck_req    = 1'b0;
      adc_valid   = 1'b0;
      @(negedge clk);
      check_val("bypass_power", 32'(power_switch), 32'd1);
      check_val("bypass_state", 32'(state), 32'd3);
      repeat (15) @(negedge clk);
      check_val("bypass_no_timeout", 32'(timeout_flag), 32'd0);
      ctrl_switch = 1'b1;
      @(negedge clk);
      check_blank();

      // 3: timeout, then sticky through a normal event
      run_cut(-1, 13'sd500, width);
      exp_count++;
      check_val("timeout_width", 32'(width), 32'd10);
      check_val("timeout_flag_set", 32'(timeout_flag), 32'd1);
      check_blank();
      run_cut(1, 13'sd1200, width);
      exp_count++;
      check_val("post_timeout_width", 32'(width), 32'd4);
      check_val("timeout_sticky", 32'(timeout_flag), 32'd1);
      check_blank();

      // 5: signed compare and threshold boundary
      run_cut(-1, -13'sd1000, width);
      check_val("negative_width", 32'(width), 32'd10);
      check_blank();
      run_cut(-1, 13'sd999, width);
      check_val("below_th_width", 32'(width), 32'd10);
      check_blank();
      run_cut(6, 13'sd1000, width);
      check_val("at_th_width", 32'(width), 32'd7);
      check_blank();
      exp_count += 3;
      check_val("boundary_count", 32'(cut_count), 32'(exp_count));

      // 6a: neck_req and ctrl_switch drop together
      neck_req    = 1'b1;
      ctrl_switch = 1'b0;
      @(negedge clk);
      neck_req    = 1'b0;
      check_val("simul_state", 32'(state), 32'd3);
      check_val("simul_count", 32'(cut_count), 32'(exp_count));
      ctrl_switch = 1'b1;
      @(negedge clk);
      check_blank();

      // 6b: reset asserted at c=2 of CUT
      neck_req = 1'b1;
      @(negedge clk);
      neck_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("pre_rst_power", 32'(power_switch), 32'd0);
      check_val("pre_rst_count", 32'(cut_count), 32'(exp_count + 1));
      rst_n = 1'b0;
      #1;
      check_val("midcut_rst_power", 32'(power_switch), 32'd0);
      check_val("midcut_rst_count", 32'(cut_count), 32'd0);
      check_val("midcut_rst_timeout", 32'(timeout_flag), 32'd0);
      check_val("midcut_rst_state", 32'(state), 32'd2);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_power", 32'(power_switch), 32'd1);
      check_val("post_rst_state", 32'(state), 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
